// File: rtl/video_pkg.sv
// Shared types and defaults for the video mode sequencer: mode payload, FSM states, counter sizing.
package video_pkg;

    typedef struct packed {
        logic sd_disable;
        logic ypbpr;
        logic ypbpr_full;
    } video_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        APPLY = 2'd2,
        POST  = 2'd3
    } vms_state_t;

    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_PRE_FRAMES     = 1;
    localparam int unsigned DEF_POST_FRAMES    = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;

    // Bits needed for a counter spanning 0..n-1 (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vsync_edge_timer.sv
// Frame-edge generator: picks the active vsync, detects rising edges and
// synthesises an edge when vsync goes missing for TIMEOUT_CYCLES.
module vsync_edge_timer
    import video_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_sel_i,
    input  logic i_rearm,
    input  logic i_rearm_sel_i,
    input  logic i_run,
    input  logic i_vsync_i,
    input  logic i_vsync_p,
    output logic o_frame_edge_c
);

    localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);

    logic             r_prev;
    logic [TMO_W-1:0] r_tmo;
    logic             w_src;
    logic             w_real_edge;
    logic             w_timeout;

    assign w_src          = i_sel_i ? i_vsync_i : i_vsync_p;
    assign w_real_edge    = w_src & ~r_prev;
    assign w_timeout      = i_run && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign o_frame_edge_c = w_real_edge | w_timeout;

    // On rearm the history tracks the source about to be selected, so the switch shows no false edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else if (i_rearm) begin
            r_prev <= i_rearm_sel_i ? i_vsync_i : i_vsync_p;
        end else begin
            r_prev <= w_src;
        end
    end

    // Idle outside PRE/POST, which also gives a fresh window on every state entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (!i_run || o_frame_edge_c) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

endmodule

// File: rtl/video_mode_sequencer.sv
// Glitch-filters the requested video mode and applies it on a frame boundary,
// blanking video for PRE_FRAMES before and POST_FRAMES after the switch.
module video_mode_sequencer
    import video_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned PRE_FRAMES     = DEF_PRE_FRAMES,
    parameter int unsigned POST_FRAMES    = DEF_POST_FRAMES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       req_sd_disable,
    input  logic       req_ypbpr,
    input  logic       req_ypbpr_full,
    input  logic       vsync_i,
    input  logic       vsync_p,
    output logic       scandoubler_disable,
    output logic       ypbpr,
    output logic       ypbpr_full,
    output logic       blank,
    output logic       busy,
    output logic [7:0] switch_count
);

    localparam int unsigned STAB_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned MAX_F  = (PRE_FRAMES > POST_FRAMES) ? PRE_FRAMES : POST_FRAMES;
    localparam int unsigned FRM_W  = cnt_width(MAX_F + 1);

    vms_state_t        r_state;
    video_cfg_t        r_req_q;
    video_cfg_t        r_applied;
    video_cfg_t        r_target;
    logic [STAB_W-1:0] r_stab;
    logic [FRM_W-1:0]  r_frame_cnt;
    logic [7:0]        r_switch_count;
    video_cfg_t        w_req;
    logic              w_frame_edge;
    logic              w_run;
    logic              w_rearm;

    assign w_req   = video_cfg_t'({req_sd_disable, req_ypbpr, req_ypbpr_full});
    assign w_run   = (r_state == PRE) || (r_state == POST);
    assign w_rearm = (r_state == APPLY);

    vsync_edge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_edge (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .i_sel_i        (r_applied.sd_disable),
        .i_rearm        (w_rearm),
        .i_rearm_sel_i  (r_target.sd_disable),
        .i_run          (w_run),
        .i_vsync_i      (vsync_i),
        .i_vsync_p      (vsync_p),
        .o_frame_edge_c (w_frame_edge)
    );

    // Reset lands in POST so the monitor always gets a clean blanked lead-in.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= POST;
            r_req_q        <= '0;
            r_applied      <= '0;
            r_target       <= '0;
            r_stab         <= '0;
            r_frame_cnt    <= FRM_W'(POST_FRAMES);
            r_switch_count <= '0;
        end else begin
            r_req_q <= w_req;
            case (r_state)
                IDLE: begin
                    if ((w_req != r_req_q) || (r_req_q == r_applied)) begin
                        r_stab <= '0;
                    end else if (r_stab == STAB_W'(STABLE_CYCLES - 1)) begin
                        r_stab      <= '0;
                        r_target    <= r_req_q;
                        r_frame_cnt <= FRM_W'(PRE_FRAMES);
                        r_state     <= PRE;
                    end else begin
                        r_stab <= r_stab + STAB_W'(1);
                    end
                end
                PRE: begin
                    r_stab <= '0;
                    if (w_frame_edge) begin
                        r_frame_cnt <= r_frame_cnt - FRM_W'(1);
                        if (r_frame_cnt == FRM_W'(1)) begin
                            r_state <= APPLY;
                        end
                    end
                end
                APPLY: begin
                    r_stab         <= '0;
                    r_applied      <= r_target;
                    r_switch_count <= r_switch_count + 8'd1;
                    r_frame_cnt    <= FRM_W'(POST_FRAMES);
                    r_state        <= POST;
                end
                POST: begin
                    r_stab <= '0;
                    if (w_frame_edge) begin
                        r_frame_cnt <= r_frame_cnt - FRM_W'(1);
                        if (r_frame_cnt == FRM_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign scandoubler_disable = r_applied.sd_disable;
    assign ypbpr               = r_applied.ypbpr;
    assign ypbpr_full          = r_applied.ypbpr_full;
    assign blank               = (r_state != IDLE);
    assign busy                = (r_state != IDLE);
    assign switch_count        = r_switch_count;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: vector table, directed corner sequences and
// random traffic, all checked cycle by cycle against a timestamp-based reference model.
module tb_video_mode_sequencer;

    localparam int S  = 8;
    localparam int PF = 1;
    localparam int QF = 2;
    localparam int T  = 64;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_sd_disable = 1'b0;
    logic       req_ypbpr = 1'b0;
    logic       req_ypbpr_full = 1'b0;
    logic       vsync_i = 1'b0;
    logic       vsync_p = 1'b0;
    logic       scandoubler_disable;
    logic       ypbpr;
    logic       ypbpr_full;
    logic       blank;
    logic       busy;
    logic [7:0] switch_count;

    video_mode_sequencer #(
        .STABLE_CYCLES  (S),
        .PRE_FRAMES     (PF),
        .POST_FRAMES    (QF),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_sys             (clk_sys),
        .reset_n             (reset_n),
        .req_sd_disable      (req_sd_disable),
        .req_ypbpr           (req_ypbpr),
        .req_ypbpr_full      (req_ypbpr_full),
        .vsync_i             (vsync_i),
        .vsync_p             (vsync_p),
        .scandoubler_disable (scandoubler_disable),
        .ypbpr               (ypbpr),
        .ypbpr_full          (ypbpr_full),
        .blank               (blank),
        .busy                (busy),
        .switch_count        (switch_count)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle_prints = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases plus timestamps of the last request change, phase entry and frame mark.
    int         cyc = 0;
    int         m_phase;          // 0 idle, 1 pre, 2 apply, 3 post
    int         m_frames;
    int         m_mark;
    int         m_idle_entry;
    int         m_last_change;
    int         m_count;
    logic [2:0] m_req_prev;
    logic [2:0] m_applied;
    logic [2:0] m_target;
    logic       m_vi_prev;
    logic       m_vp_prev;

    task automatic m_init();
        m_phase       = 3;
        m_frames      = QF;
        m_mark        = cyc + 1;
        m_idle_entry  = 0;
        m_last_change = -1000000;
        m_count       = 0;
        m_req_prev    = 3'b000;
        m_applied     = 3'b000;
        m_target      = 3'b000;
        m_vi_prev     = 1'b0;
        m_vp_prev     = 1'b0;
    endtask

    task automatic model_update();
        logic [2:0] cur;
        logic       src;
        logic       srcp;
        logic       fe;
        int         st;
        if (!reset_n) begin
            m_init();
            return;
        end
        cur = {req_sd_disable, req_ypbpr, req_ypbpr_full};
        if (cur != m_req_prev) m_last_change = cyc;
        src  = m_applied[2] ? vsync_i : vsync_p;
        srcp = m_applied[2] ? m_vi_prev : m_vp_prev;
        fe   = (src && !srcp) || ((cyc - m_mark) == T - 1);
        case (m_phase)
            0: begin
                st = (m_last_change + 1 > m_idle_entry) ? m_last_change + 1 : m_idle_entry;
                if (cur != m_applied && (cyc - st + 1) == S) begin
                    m_target = cur;
                    m_phase  = 1;
                    m_frames = PF;
                    m_mark   = cyc + 1;
                end
            end
            1, 3: begin
                if (fe) begin
                    m_frames--;
                    m_mark = cyc + 1;
                    if (m_frames == 0) begin
                        if (m_phase == 1) begin
                            m_phase = 2;
                        end else begin
                            m_phase      = 0;
                            m_idle_entry = cyc + 1;
                        end
                    end
                end
            end
            default: begin
                m_applied = m_target;
                m_count   = (m_count + 1) % 256;
                m_phase   = 3;
                m_frames  = QF;
                m_mark    = cyc + 1;
            end
        endcase
        m_req_prev = cur;
        m_vi_prev  = vsync_i;
        m_vp_prev  = vsync_p;
    endtask

    task automatic tick();
        logic [12:0] act;
        logic [12:0] exp;
        @(posedge clk_sys);
        cyc++;
        model_update();
        @(negedge clk_sys);
        act = {scandoubler_disable, ypbpr, ypbpr_full, blank, busy, switch_count};
        exp = {m_applied, m_phase != 0, m_phase != 0, 8'(m_count)};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_cycle_prints < 20) begin
                n_cycle_prints++;
                $display("FAIL cycle %0d model: got %h expected %h", cyc, act, exp);
            end
        end
    endtask

    task automatic set_req(input logic [2:0] r);
        {req_sd_disable, req_ypbpr, req_ypbpr_full} = r;
    endtask

    function automatic logic [31:0] outs();
        return 32'({scandoubler_disable, ypbpr, ypbpr_full, blank, busy, switch_count});
    endfunction

    typedef struct {
        int         ncyc;
        logic [2:0] req;
        logic       vp;
        logic       vi;
        logic [2:0] mode;
        logic       blk;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int n, input logic [2:0] r, input logic vp, input logic vi,
                           input logic [2:0] m, input logic b, input logic [7:0] c);
        vec_t v;
        v.ncyc = n; v.req = r; v.vp = vp; v.vi = vi; v.mode = m; v.blk = b; v.cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;

        // Reset release, glitch rejection, then a ypbpr switch paced by vsync_p.
        add_vec(1,  3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 8'd0);
        add_vec(1,  3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 8'd0);
        add_vec(3,  3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 8'd0);
        add_vec(1,  3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 8'd0);
        add_vec(2,  3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0);
        add_vec(5,  3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0);
        add_vec(12, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0);
        add_vec(8,  3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0);
        add_vec(1,  3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 8'd0);
        add_vec(1,  3'b010, 1'b1, 1'b0, 3'b000, 1'b1, 8'd0);
        add_vec(1,  3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 8'd1);
        add_vec(1,  3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 8'd1);
        add_vec(3,  3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 8'd1);
        add_vec(1,  3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 8'd1);
        add_vec(2,  3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 8'd1);

        repeat (3) tick();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            set_req(vecs[i].req);
            vsync_p = vecs[i].vp;
            vsync_i = vecs[i].vi;
            repeat (vecs[i].ncyc) tick();
            check($sformatf("vec%0d", i), outs(),
                  32'({vecs[i].mode, vecs[i].blk, vecs[i].blk, vecs[i].cnt}));
        end
        vsync_p = 1'b0;
        vsync_i = 1'b0;

        // sd_disable 0->1: PRE on vsync_p, POST only on vsync_i.
        set_req(3'b110);
        n = 0;
        while (!blank && n < 30) begin tick(); n++; end
        check("sd_commit_latency", 32'(n), 32'(S + 1));
        vsync_p = 1'b1; tick();
        vsync_p = 1'b0; tick();
        check("sd_applied", outs(), 32'({3'b110, 1'b1, 1'b1, 8'd2}));
        for (int i = 0; i < 5; i++) begin
            vsync_p = 1'b1; tick();
            vsync_p = 1'b0; tick(); tick();
        end
        check("sd_ignores_vsync_p", 32'(blank), 32'd1);
        vsync_i = 1'b1; tick();
        vsync_i = 1'b0; tick();
        check("sd_post_mid", 32'(blank), 32'd1);
        vsync_i = 1'b1; tick();
        vsync_i = 1'b0;
        check("sd_post_done", outs(), 32'({3'b110, 1'b0, 1'b0, 8'd2}));
        tick();

        // No vsync at all: both phases advance on timeouts only.
        set_req(3'b100);
        n = 0;
        while (!blank && n < 30) begin tick(); n++; end
        check("to_commit", 32'(blank), 32'd1);
        n = 0;
        while (blank && {scandoubler_disable, ypbpr, ypbpr_full} == 3'b110 && n < 300) begin
            tick(); n++;
        end
        check("to_pre_plus_apply_len", 32'(n), 32'(T + 1));
        check("to_mode", outs(), 32'({3'b100, 1'b1, 1'b1, 8'd3}));
        m = 0;
        while (blank && m < 300) begin tick(); m++; end
        check("to_post_len", 32'(m), 32'(2 * T));

        // Reset pulse mid-POST after a switch to 110.
        set_req(3'b110);
        n = 0;
        while ({scandoubler_disable, ypbpr, ypbpr_full} != 3'b110 && n < 150) begin tick(); n++; end
        check("rst_pre_mode", 32'({scandoubler_disable, ypbpr, ypbpr_full}), 32'(3'b110));
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("rst_async", outs(), 32'({3'b000, 1'b1, 1'b1, 8'd0}));
        tick();
        reset_n = 1'b1;
        n = 0;
        while ({scandoubler_disable, ypbpr, ypbpr_full} != 3'b110 && n < 400) begin tick(); n++; end
        check("rst_reswitch", outs(), 32'({3'b110, 1'b1, 1'b1, 8'd1}));

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 49) == 0) set_req(3'($urandom_range(0, 7)));
            vsync_p = ($urandom_range(0, 19) == 0);
            vsync_i = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
